// File: rtl/trng_sampler_if.sv
// ============================================================================
// Module  : trng_sampler_if
// Purpose : LFSR control and sample-stream bundle for trng_sampler
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface trng_sampler_if #(
   parameter int WIDTH      = 10,
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             run;
   logic [WIDTH-1:0] seed_in;
   logic [WIDTH-1:0] lfsr_data;
   logic             lfsr_en;
   logic             lfsr_seed_we;
   logic [WIDTH-1:0] lfsr_seed;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [LVL_W-1:0] fifo_level;
   logic             health_fail;

   modport master (
      output run, seed_in, lfsr_data, out_ready,
      input  lfsr_en, lfsr_seed_we, lfsr_seed, out_data, out_valid, fifo_level, health_fail
   );

   modport slave (
      input  run, seed_in, lfsr_data, out_ready,
      output lfsr_en, lfsr_seed_we, lfsr_seed, out_data, out_valid, fifo_level, health_fail
   );
endinterface

`default_nettype wire

// File: rtl/trng_sampler.sv
// ============================================================================
// Module  : trng_sampler
// Purpose : Seeds and decimates an LFSR, buffers captures in a show-ahead FIFO.
//           Define TRNG_HEALTH_EN for the repetition-count health test.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module trng_sampler #(
   parameter int WIDTH      = 10,
   parameter int DECIM      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int RCT_LIMIT  = 3
) (
   input  wire logic      clk,
   input  wire logic      rst,
   trng_sampler_if.slave  bus
);
   localparam int CNT_W = $clog2(DECIM) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEED    = 3'd1,
      ST_RUN     = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_HALT    = 3'd4
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             lfsr_en_q;
   logic             seed_we_q;
   logic [WIDTH-1:0] seed_q;

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic [WIDTH-1:0] out_data_q;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_take;
   logic w_push;
   logic w_rct_trip;
   logic w_health_fail;

   assign w_full  = (level_q == LVL_FULL);
   assign w_empty = (level_q == '0);
   assign w_pop   = !w_empty && bus.out_ready;
   // A capture completes only when there is room for it (a pop this cycle frees one slot).
   assign w_take  = (state_q == ST_CAPTURE) && bus.run && (!w_full || w_pop);
   assign w_push  = w_take && !w_rct_trip;

`ifdef TRNG_HEALTH_EN
   localparam int RCT_W = $clog2(RCT_LIMIT + 1);
   localparam logic [RCT_W-1:0] RCT_MAX = RCT_W'(RCT_LIMIT);

   logic [WIDTH-1:0] prev_q;
   logic             has_prev_q;
   logic [RCT_W-1:0] rep_q;
   logic [RCT_W-1:0] rep_d;
   logic             fail_q;

   always_comb begin
      rep_d = RCT_W'(1);
      if (has_prev_q && (bus.lfsr_data == prev_q)) begin
         rep_d = (rep_q == RCT_MAX) ? rep_q : rep_q + RCT_W'(1);
      end
   end

   assign w_rct_trip    = w_take && (rep_d >= RCT_MAX);
   assign w_health_fail = fail_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         has_prev_q <= 1'b0;
         rep_q      <= '0;
         fail_q     <= 1'b0;
      end else if (w_take) begin
         prev_q     <= bus.lfsr_data;
         has_prev_q <= 1'b1;
         rep_q      <= rep_d;
         if (w_rct_trip) begin
            fail_q <= 1'b1;
         end
      end
   end
`else
   assign w_rct_trip    = 1'b0;
   assign w_health_fail = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         lfsr_en_q <= 1'b0;
         seed_we_q <= 1'b0;
         seed_q    <= '0;
      end else begin
         seed_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               lfsr_en_q <= 1'b0;
               if (bus.run) begin
                  state_q   <= ST_SEED;
                  seed_we_q <= 1'b1;
                  seed_q    <= bus.seed_in;
               end
            end
            ST_SEED: begin
               cnt_q <= '0;
               if (!bus.run) begin
                  state_q   <= ST_IDLE;
                  lfsr_en_q <= 1'b0;
               end else begin
                  state_q   <= ST_RUN;
                  lfsr_en_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!bus.run) begin
                  state_q   <= ST_IDLE;
                  lfsr_en_q <= 1'b0;
                  cnt_q     <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= ST_CAPTURE;
                  lfsr_en_q <= 1'b0;
                  cnt_q     <= '0;
               end else begin
                  cnt_q     <= cnt_q + CNT_W'(1);
                  lfsr_en_q <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (!bus.run) begin
                  state_q   <= ST_IDLE;
                  lfsr_en_q <= 1'b0;
               end else if (w_rct_trip) begin
                  state_q   <= ST_HALT;
                  lfsr_en_q <= 1'b0;
               end else if (w_take) begin
                  state_q   <= ST_RUN;
                  lfsr_en_q <= 1'b1;
                  cnt_q     <= '0;
               end else begin
                  lfsr_en_q <= 1'b0;
               end
            end
            ST_HALT: begin
               lfsr_en_q <= 1'b0;
            end
            default: begin
               state_q   <= ST_IDLE;
               lfsr_en_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= bus.lfsr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         out_data_q <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
         // Head register keeps the last head value once the FIFO runs empty.
         if (w_pop && (level_q > LVL_W'(1))) begin
            out_data_q <= mem_q[rd_ptr_q + PTR_W'(1)];
         end else if (w_push && (w_empty || (w_pop && (level_q == LVL_W'(1))))) begin
            out_data_q <= bus.lfsr_data;
         end
      end
   end

   assign bus.lfsr_en      = lfsr_en_q;
   assign bus.lfsr_seed_we = seed_we_q;
   assign bus.lfsr_seed    = seed_q;
   assign bus.out_data     = out_data_q;
   assign bus.out_valid    = !w_empty;
   assign bus.fifo_level   = level_q;
   assign bus.health_fail  = w_health_fail;

endmodule

`default_nettype wire

// File: tb/tb_trng_sampler.sv
// ============================================================================
// Module  : tb_trng_sampler
// Purpose : Directed table-driven bench for trng_sampler with a behavioural LFSR.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trng_sampler;
   localparam int W = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_ones = 1'b0;
   logic [W-1:0] lfsr_q = '0;
   int n_cmp = 0;
   int n_fail = 0;

   trng_sampler_if #(.WIDTH(W), .FIFO_DEPTH(4)) bus ();

   trng_sampler #(.WIDTH(W), .DECIM(4), .FIFO_DEPTH(4), .RCT_LIMIT(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
      return {s[W-2:0], s[9] ^ s[6]};
   endfunction

   function automatic logic [W-1:0] exp_after(input logic [W-1:0] seed, input int n);
      logic [W-1:0] s = seed;
      for (int i = 0; i < n; i++) s = lfsr_step(s);
      return s;
   endfunction

   // Behavioural LFSR the sampler controls.
   always @(posedge clk) begin
      if (rst)                    lfsr_q <= '0;
      else if (bus.lfsr_seed_we)  lfsr_q <= bus.lfsr_seed;
      else if (bus.lfsr_en)       lfsr_q <= lfsr_step(lfsr_q);
   end
   assign bus.lfsr_data = force_ones ? 10'h3FF : lfsr_q;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.run = 1'b0;
      bus.out_ready = 1'b0;
      force_ones = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      logic we;
      logic en;
      logic valid;
      int   nshift;
   } vec_t;

   vec_t vt[17];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int idx;
      int en_seen;
      vt[0]  = '{1'b1, 1'b0, 1'b0, 0};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 0};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 0};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 0};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 0};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 0};
      vt[6]  = '{1'b0, 1'b1, 1'b1, 4};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 0};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 0};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 0};
      vt[11] = '{1'b0, 1'b1, 1'b1, 8};
      vt[12] = '{1'b0, 1'b1, 1'b0, 0};
      vt[13] = '{1'b0, 1'b1, 1'b0, 0};
      vt[14] = '{1'b0, 1'b1, 1'b0, 0};
      vt[15] = '{1'b0, 1'b0, 1'b0, 0};
      vt[16] = '{1'b0, 1'b1, 1'b1, 12};

      bus.run = 1'b0;
      bus.seed_in = 10'h155;
      bus.out_ready = 1'b0;

      // 1: reset state
      do_reset();
      chk("rst_en", bus.lfsr_en, 0);
      chk("rst_we", bus.lfsr_seed_we, 0);
      chk("rst_seed", bus.lfsr_seed, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_health", bus.health_fail, 0);

      // 2: seeding, decimation and output timing
      bus.run = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         chk($sformatf("t2_we_c%0d", c + 1), bus.lfsr_seed_we, vt[c].we);
         chk($sformatf("t2_en_c%0d", c + 1), bus.lfsr_en, vt[c].en);
         chk($sformatf("t2_valid_c%0d", c + 1), bus.out_valid, vt[c].valid);
         if (c == 0) chk("t2_seed", bus.lfsr_seed, 10'h155);
         if (vt[c].valid)
            chk($sformatf("t2_data_c%0d", c + 1), bus.out_data, exp_after(10'h155, vt[c].nshift));
      end

      // 3: backpressure fills FIFO, capture holds, drain in order
      do_reset();
      bus.run = 1'b1;
      cycles(30);
      chk("t3_level_full", bus.fifo_level, 4);
      chk("t3_en_held", bus.lfsr_en, 0);
      bus.out_ready = 1'b1;
      idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         if (bus.out_valid) begin
            chk($sformatf("t3_drain%0d", idx), bus.out_data, exp_after(10'h155, 4 * (idx + 1)));
            idx++;
         end
         @(negedge clk);
      end
      chk("t3_drained_count", idx, 6);

      // 4: run dropped mid-RUN, then restart with a new seed
      do_reset();
      bus.run = 1'b1;
      cycles(9);
      chk("t4_en_run", bus.lfsr_en, 1);
      chk("t4_level1", bus.fifo_level, 1);
      bus.run = 1'b0;
      cycles(1);
      chk("t4_en_stop", bus.lfsr_en, 0);
      chk("t4_level_kept", bus.fifo_level, 1);
      chk("t4_data_kept", bus.out_data, exp_after(10'h155, 4));
      cycles(2);
      chk("t4_en_idle", bus.lfsr_en, 0);
      bus.seed_in = 10'h2A5;
      bus.run = 1'b1;
      cycles(1);
      chk("t4_reseed_we", bus.lfsr_seed_we, 1);
      chk("t4_reseed_en", bus.lfsr_en, 0);
      chk("t4_reseed_val", bus.lfsr_seed, 10'h2A5);
      cycles(1);
      chk("t4_en_after_seed", bus.lfsr_en, 1);
      cycles(5);
      chk("t4_level2", bus.fifo_level, 2);
      bus.out_ready = 1'b1;
      chk("t4_pop_old", bus.out_data, exp_after(10'h155, 4));
      cycles(1);
      chk("t4_pop_new", bus.out_data, exp_after(10'h2A5, 4));
      bus.seed_in = 10'h155;

      // 5: stuck entropy
      do_reset();
      force_ones = 1'b1;
      bus.run = 1'b1;
`ifdef TRNG_HEALTH_EN
      cycles(17);
      chk("t5_health", bus.health_fail, 1);
      chk("t5_level", bus.fifo_level, 2);
      en_seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.lfsr_en) en_seen++;
      end
      chk("t5_halt_en", en_seen, 0);
      chk("t5_health_sticky", bus.health_fail, 1);
      bus.out_ready = 1'b1;
      cycles(3);
      chk("t5_drain_level", bus.fifo_level, 0);
      chk("t5_drain_data", bus.out_data, 10'h3FF);
      chk("t5_halt_en2", bus.lfsr_en, 0);
`else
      cycles(25);
      chk("t5_health_off", bus.health_fail, 0);
      chk("t5_level_full", bus.fifo_level, 4);
      chk("t5_data", bus.out_data, 10'h3FF);
`endif

      // 6: reset with FIFO full and capture pending
      do_reset();
      bus.run = 1'b1;
      cycles(30);
      chk("t6_pre_level", bus.fifo_level, 4);
      rst = 1'b1;
      bus.run = 1'b0;
      cycles(1);
      chk("t6_level", bus.fifo_level, 0);
      chk("t6_valid", bus.out_valid, 0);
      chk("t6_en", bus.lfsr_en, 0);
      chk("t6_data", bus.out_data, 0);
      rst = 1'b0;
      cycles(2);
      chk("t6_idle_en", bus.lfsr_en, 0);
      chk("t6_idle_we", bus.lfsr_seed_we, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
